baugh_divider_seq: RTL and testbench



---
 rtl/div_pkg.sv | 31 +++
 rtl/div_step.sv | 27 ++
 rtl/baugh_divider_seq.sv | 124 ++++++++++++
 tb/tb_baugh_divider_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider and its reference models.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_e;

    localparam int MAX_W = 32;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

    // Magnitude of a w-bit two's-complement value, one bit wider so -2^(w-1) fits.
    function automatic logic [MAX_W:0] abs_ext(input logic [MAX_W-1:0] value, input int w);
        logic [MAX_W:0] one;
        logic [MAX_W:0] span;
        logic [MAX_W:0] low;
        one  = {{MAX_W{1'b0}}, 1'b1};
        span = one << w;
        low  = {1'b0, value} & (span - one);
        if (((low >> (w - 1)) & one) != '0) begin
            return span - low;
        end
        return low;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step on magnitudes: shift {rem, quo} left, trial-subtract divisor.
// Purely combinational, zero latency; no handshake.
// Backpressure: none, the caller decides when the result is registered.
module div_step #(
    parameter int W = 4
) (
    input  logic [W:0] rem,
    input  logic [W:0] quo,
    input  logic [W:0] dsr_mag,
    output logic [W:0] rem_nxt,
    output logic [W:0] quo_nxt
);

    logic [W+1:0] minuend;
    logic [W+1:0] trial;
    logic         q_bit;

    // rem stays below |divisor| <= 2^(W-1), so the W+2-bit difference never wraps.
    always_comb begin
        minuend = {rem, quo[W]};
        trial   = minuend - {1'b0, dsr_mag};
        q_bit   = ~trial[W+1];
        rem_nxt = q_bit ? trial[W:0] : minuend[W:0];
        quo_nxt = {quo[W-1:0], q_bit};
    end

endmodule

// File: rtl/baugh_divider_seq.sv
// Sequential signed divider: restoring iteration on magnitudes, then sign fix-up.
// Latency: accept -> CALC (W cycles) -> FIX (1) -> DONE; result taken W+2 edges after acceptance.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, busy inputs ignored.
module baugh_divider_seq
    import div_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero,
    output logic         overflow
);

    localparam int CNT_W = cnt_width(W);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [W:0]       rem;
    logic [W:0]       quo;
    logic [W:0]       dsr_mag;
    logic [W:0]       rem_nxt;
    logic [W:0]       quo_nxt;
    logic             sign_q;
    logic             sign_r;
    logic             dz_r;
    logic             ov_r;

    div_step #(.W(W)) u_step (
        .rem     (rem),
        .quo     (quo),
        .dsr_mag (dsr_mag),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = CALC;
            CALC: if (cnt == CNT_W'(W - 1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            rem         <= '0;
            quo         <= '0;
            dsr_mag     <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz_r        <= 1'b0;
            ov_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cnt     <= '0;
                        rem     <= '0;
                        // Pre-shifted so quo[W] feeds the dividend MSB into rem on the first step.
                        quo     <= (W+1)'(abs_ext(32'(dividend), W) << 1);
                        dsr_mag <= (W+1)'(abs_ext(32'(divisor), W));
                        sign_q  <= dividend[W-1] ^ divisor[W-1];
                        sign_r  <= dividend[W-1];
                        dz_r    <= (divisor == '0);
                        ov_r    <= (dividend == {1'b1, {(W-1){1'b0}}}) && (divisor == '1);
                    end
                end
                CALC: begin
                    rem <= rem_nxt;
                    quo <= quo_nxt;
                    cnt <= cnt + CNT_W'(1);
                end
                FIX: begin
                    div_by_zero <= dz_r;
                    overflow    <= ov_r;
                    if (dz_r) begin
                        // With a zero divisor every trial succeeds, leaving |dividend| in rem.
                        quotient  <= '1;
                        remainder <= W'(sign_r ? -rem : rem);
                    end else if (ov_r) begin
                        quotient  <= {1'b1, {(W-1){1'b0}}};
                        remainder <= '0;
                    end else begin
                        quotient  <= W'(sign_q ? -quo : quo);
                        remainder <= W'(sign_r ? -rem : rem);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_baugh_divider_seq.sv
// Scoreboard bench for baugh_divider_seq at W=4: directed cases, back-pressure, mid-op reset, full sweep.
module tb_baugh_divider_seq;

    localparam int W       = 4;
    localparam int LAT     = W + 2;
    localparam int MAXWAIT = 40;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } res_t;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] dividend  = '0;
    logic [W-1:0] divisor   = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    res_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   keep_rdy = 1'b0;

    always #5 clk = ~clk;

    baugh_divider_seq #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input int a, input int b);
        res_t m;
        int   q;
        int   r;
        m.dz = 1'b0;
        m.ov = 1'b0;
        if (b == 0) begin
            q    = -1;
            r    = a;
            m.dz = 1'b1;
        end else if (a == -(1 << (W - 1)) && b == -1) begin
            q    = a;
            r    = 0;
            m.ov = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
        end
        m.q = q[W-1:0];
        m.r = r[W-1:0];
        return m;
    endfunction

    // Leaves the caller at the negedge right after the accepting edge.
    task automatic send(input int a, input int b);
        int k;
        k = 0;
        while (!in_ready && k < MAXWAIT) begin
            @(negedge clk);
            k++;
        end
        chk("in_ready_before_send", in_ready, 1);
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        in_valid = 1'b1;
        exp_q.push_back(model(a, b));
        @(negedge clk);
        in_valid = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        chk("busy_in_ready", in_ready, 0);
    endtask

    // k is the edge on which the sample seen at this negedge would be taken.
    task automatic recv(input int hold, input bit poke);
        int   k;
        res_t e;
        k = 1;
        while (!out_valid && k < MAXWAIT) begin
            @(negedge clk);
            k++;
        end
        chk("latency", k, LAT);
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
            return;
        end
        e = exp_q.pop_front();
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = poke;
            dividend  = 4'h1;
            divisor   = 4'h1;
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_quotient", quotient, e.q);
            chk("hold_remainder", remainder, e.r);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("quotient", quotient, e.q);
        chk("remainder", remainder, e.r);
        chk("flags", {div_by_zero, overflow}, {e.dz, e.ov});
        @(negedge clk);
        out_ready = keep_rdy;
        chk("post_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
        chk("persist_quotient", quotient, e.q);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_flags", {div_by_zero, overflow}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(7, 2);   recv(0, 1'b0);
        send(-7, 2);  recv(0, 1'b0);
        send(7, -2);  recv(0, 1'b0);
        send(-7, -2); recv(0, 1'b0);
        send(-8, -1); recv(0, 1'b0);
        send(5, 0);   recv(0, 1'b0);

        // Result stalled 3 cycles with a stray operand pulse that must not be taken.
        send(6, 3);   recv(3, 1'b1);
        repeat (3) begin
            @(negedge clk);
            chk("no_queued_op", out_valid, 0);
        end

        // Abort on the second CALC cycle; the partial result must never appear.
        send(5, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 0);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        void'(exp_q.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(3, 1);   recv(0, 1'b0);

        keep_rdy  = 1'b1;
        out_ready = 1'b1;
        for (int a = -(1 << (W - 1)); a < (1 << (W - 1)); a++) begin
            for (int b = -(1 << (W - 1)); b < (1 << (W - 1)); b++) begin
                send(a, b);
                recv(0, 1'b0);
            end
        end
        out_ready = 1'b0;
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
